// File: rtl/negacyclic_reduce_stream.sv
// Folds a (2D-1)-coefficient product modulo x^D + 1, reduces each coefficient
// modulo Q, and streams the D results out one per cycle over valid/ready.
module negacyclic_reduce_stream #(
  parameter int N = 2,
  parameter int D = 4,
  parameter int Q = 3,
  localparam int PW = (2*D-1)*2*N,
  localparam int IW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_p,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_coef,
  output logic [IW-1:0] out_idx,
  output logic          out_last
);

  // state | meaning
  // IDLE  | waiting for a product, in_ready high
  // EMIT  | streaming r_0..r_{D-1} from the capture buffer
  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [2*N:0] QW = (2*N+1)'(Q);

  state_t          state;
  logic [PW-1:0]   cap_buf;
  logic [N-1:0]    r_buf [D];
  logic [N-1:0]    r0_in;
  logic [IW-1:0]   idx_nxt;

  // (lo - hi) mod Q with both operands reduced first, so no borrow below zero
  function automatic logic [N-1:0] reduce_pair(input logic [2*N-1:0] lo,
                                                input logic [2*N-1:0] hi);
    logic [2*N:0] a, b, s;
    a = {1'b0, lo} % QW;
    b = {1'b0, hi} % QW;
    s = (a >= b) ? (a - b) : (a + QW - b);
    return s[N-1:0];
  endfunction

  for (genvar j = 0; j < D; j++) begin : g_r
    if (j < D-1) begin : g_wrap
      assign r_buf[j] = reduce_pair(cap_buf[j*2*N +: 2*N], cap_buf[(j+D)*2*N +: 2*N]);
    end else begin : g_top
      assign r_buf[j] = reduce_pair(cap_buf[j*2*N +: 2*N], '0);
    end
  end

  if (D > 1) begin : g_r0
    assign r0_in = reduce_pair(in_p[0 +: 2*N], in_p[D*2*N +: 2*N]);
  end else begin : g_r0_single
    assign r0_in = reduce_pair(in_p[0 +: 2*N], '0);
  end

  assign idx_nxt = out_idx + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_coef  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      cap_buf   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            cap_buf   <= in_p;
            out_coef  <= r0_in;
            out_idx   <= '0;
            out_last  <= (D == 1);
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              state     <= IDLE;
            end else begin
              out_idx  <= idx_nxt;
              out_coef <= r_buf[idx_nxt];
              out_last <= (idx_nxt == IW'(D-1));
            end
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_negacyclic_reduce_stream.sv
// Bench for negacyclic_reduce_stream: directed and random products checked
// against an integer negacyclic-fold model, with backpressure and reset cases.
module tb_negacyclic_reduce_stream;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int Q  = 3;
  localparam int PW = (2*D-1)*2*N;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_p;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_coef;
  logic [IW-1:0] out_idx;
  logic          out_last;

  int n_checks = 0;
  int n_fail   = 0;
  int n_emitted = 0;

  always #5 clk = ~clk;

  negacyclic_reduce_stream #(.N(N), .D(D), .Q(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: r_j = (c_j - c_{j+D}) mod Q as plain signed integers
  task automatic model(input logic [PW-1:0] p, output int r [D]);
    for (int j = 0; j < D; j++) begin
      int v;
      v = int'(p[j*2*N +: 2*N]);
      if (j < D-1) v = v - int'(p[(j+D)*2*N +: 2*N]);
      r[j] = ((v % Q) + Q) % Q;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: out_ready=1; 1: fixed toggle pattern; 2: random.
  // Called at a sample point with in_ready expected high.
  task automatic run_poly(input logic [PW-1:0] p, input int mode, input bit hold_valid,
                          input int stop_after);
    int  exp [D];
    int  k;
    int  cyc;
    bit  stall;
    logic [N-1:0]  sv_coef;
    logic [IW-1:0] sv_idx;
    logic          sv_last;
    bit  pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    model(p, exp);
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_p     = p;
    out_ready = 1'b0;
    step();
    in_valid = hold_valid;
    in_p     = PW'({$urandom, $urandom});
    chk("first_valid_latency", out_valid, 1);
    k = 0; cyc = 0; stall = 1'b0;
    while (k < stop_after && cyc < 60) begin
      if (stall) begin
        chk("hold_coef", out_coef, sv_coef);
        chk("hold_idx", out_idx, sv_idx);
        chk("hold_last", out_last, sv_last);
        chk("hold_valid", out_valid, 1);
      end
      chk("in_ready_low_emit", in_ready, 0);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc < 7) ? pat[cyc] : 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        chk("coef", out_coef, exp[k]);
        chk("idx", out_idx, k);
        chk("last", out_last, (k == D-1));
        k++;
        n_emitted++;
        stall = 1'b0;
      end else begin
        stall = out_valid;
        sv_coef = out_coef; sv_idx = out_idx; sv_last = out_last;
      end
      step();
      cyc++;
    end
    chk("handshake_count", k, stop_after);
    out_ready = 1'b0;
    if (stop_after == D) begin
      chk("valid_low_after_last", out_valid, 0);
      chk("in_ready_after_last", in_ready, 1);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [PW-1:0] rp;
    rst = 1'b1; in_valid = 1'b0; in_p = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_coef", out_coef, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b0;
    step();

    run_poly(28'h0000121, 0, 1'b0, D);
    run_poly(28'h0010000, 0, 1'b0, D);
    run_poly({4'd0, 4'd9, 4'd4, 4'd7, 4'd14, 4'd9, 4'd15}, 0, 1'b0, D);
    run_poly(28'h0000121, 1, 1'b1, D);
    step();

    // reset after the second handshake, mid-cycle
    run_poly(28'h0000121, 0, 1'b0, 2);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_idx", out_idx, 0);
    #1;
    rst = 1'b0;
    step();
    chk("post_rst_valid", out_valid, 0);
    run_poly(28'h0010000, 0, 1'b0, D);

    // back-to-back with in_valid held high throughout
    n_emitted = 0;
    run_poly(28'h0000121, 0, 1'b1, D);
    run_poly(28'h0010000, 0, 1'b1, D);
    chk("b2b_total", n_emitted, 2*D);

    for (int t = 0; t < 20; t++) begin
      rp = PW'({$urandom, $urandom});
      run_poly(rp, 2, 1'($urandom_range(0, 1)), D);
    end
    for (int t = 0; t < 6; t++) begin
      rp = '0;
      for (int i = 0; i < 2*D-1; i++) rp[i*2*N +: 2*N] = (t[0]) ? '1 : 4'($urandom);
      run_poly(rp, 0, 1'b0, D);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
